fetch_stage_control: RTL and testbench

- Consumer side of the stall/flush interface driven by the hazard detection unit.
- Owns the PC register and the IF/ID pipeline register.
- Applies stall (hold PC and IF/ID), flush (inject a bubble into ID/EX) and taken-branch redirect (squash IF/ID).
- Sits between instruction memory and the ID stage. Also supervises stall duration with a watchdog.

---
 rtl/fetch_stage_control_if.sv | 25 ++
 rtl/fetch_stage_control.sv | 139 +++++++++++++
 tb/tb_fetch_stage_control.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_control_if.sv
// Stall/flush/redirect bundle between the hazard unit, instruction memory and the fetch stage.
// The master side drives the hazard and memory inputs. The slave side is the fetch stage.
interface fetch_stage_control_if;
  logic        stall;
  logic        flush;
  logic        ID_branch_taken;
  logic [31:0] ID_branch_target;
  logic [31:0] IF_instruction;
  logic [31:0] IF_pc;
  logic [31:0] ID_instruction;
  logic [31:0] ID_pc_plus4;
  logic        ID_valid;
  logic        EX_bubble;
  logic        stall_error;

  modport master (
    output stall, flush, ID_branch_taken, ID_branch_target, IF_instruction,
    input  IF_pc, ID_instruction, ID_pc_plus4, ID_valid, EX_bubble, stall_error
  );

  modport slave (
    input  stall, flush, ID_branch_taken, ID_branch_target, IF_instruction,
    output IF_pc, ID_instruction, ID_pc_plus4, ID_valid, EX_bubble, stall_error
  );
endinterface

// File: rtl/fetch_stage_control.sv
// Fetch stage: PC register, IF/ID register, stall/flush/redirect handling and a stall watchdog.
// Optional FETCH_PERF_COUNTERS_EN adds stall/bubble/squash performance counters.
module fetch_stage_control #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MAX_STALL = 4,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
  input  logic clk,
  input  logic reset,
  fetch_stage_control_if.slave bus
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_cycles,
  output logic [31:0] perf_squashes
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

  localparam logic [4:0] MAX_STALL_W = 5'(MAX_STALL);

  state_t      state, state_next;
  logic [31:0] pc, pc_next, pc_plus4;
  logic [31:0] id_instr, id_instr_next;
  logic [31:0] id_pc4, id_pc4_next;
  logic        id_valid, id_valid_next;
  logic        redirect;
  logic [3:0]  stall_cnt, stall_cnt_next;
  logic [4:0]  stall_cnt_inc;
  logic        stall_err, stall_err_next;
  logic        ex_bubble;

  assign pc_plus4 = pc + 32'd4;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      id_instr  <= NOP_WORD;
      id_pc4    <= 32'd0;
      id_valid  <= 1'b0;
      stall_cnt <= 4'd0;
      stall_err <= 1'b0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      id_instr  <= id_instr_next;
      id_pc4    <= id_pc4_next;
      id_valid  <= id_valid_next;
      stall_cnt <= stall_cnt_next;
      stall_err <= stall_err_next;
    end
  end

  // BOOT always fetches so the pipeline fills even if the hazard unit is
  // still settling. A stall outranks a redirect, so the branch re-resolves later.
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    id_instr_next = id_instr;
    id_pc4_next   = id_pc4;
    id_valid_next = id_valid;
    redirect      = 1'b0;
    case (state)
      BOOT: begin
        state_next    = RUN;
        pc_next       = pc_plus4;
        id_instr_next = bus.IF_instruction;
        id_pc4_next   = pc_plus4;
        id_valid_next = 1'b1;
      end
      RUN, HOLD: begin
        state_next = bus.stall ? HOLD : RUN;
        if (!bus.stall) begin
          if (bus.ID_branch_taken) begin
            redirect      = 1'b1;
            pc_next       = bus.ID_branch_target;
            id_instr_next = NOP_WORD;
            id_valid_next = 1'b0;
          end else begin
            pc_next       = pc_plus4;
            id_instr_next = bus.IF_instruction;
            id_pc4_next   = pc_plus4;
            id_valid_next = 1'b1;
          end
        end
      end
      default: state_next = BOOT;
    endcase
  end

  // The watchdog counts in every state. The error flag is sticky until reset.
  always_comb begin
    stall_cnt_inc  = {1'b0, stall_cnt} + 5'd1;
    stall_cnt_next = 4'd0;
    stall_err_next = stall_err;
    if (bus.stall) begin
      stall_cnt_next = (stall_cnt == 4'd15) ? 4'd15 : stall_cnt_inc[3:0];
      if (stall_cnt_inc >= MAX_STALL_W) begin
        stall_err_next = 1'b1;
      end
    end
  end

  assign ex_bubble = reset | bus.flush | bus.stall | ~id_valid;

  assign bus.IF_pc          = pc;
  assign bus.ID_instruction = id_instr;
  assign bus.ID_pc_plus4    = id_pc4;
  assign bus.ID_valid       = id_valid;
  assign bus.EX_bubble      = ex_bubble;
  assign bus.stall_error    = stall_err;

`ifdef FETCH_PERF_COUNTERS_EN
  // Bubble cycles in BOOT are excluded because they are only pipeline fill.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cycles <= 32'd0;
      perf_flush_cycles <= 32'd0;
      perf_squashes     <= 32'd0;
    end else begin
      if (bus.stall) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
      if (ex_bubble && (state != BOOT)) begin
        perf_flush_cycles <= perf_flush_cycles + 32'd1;
      end
      if (redirect) begin
        perf_squashes <= perf_squashes + 32'd1;
      end
    end
  end
`else
  logic unused_redirect;
  assign unused_redirect = redirect;
`endif

endmodule

// File: tb/tb_fetch_stage_control.sv
// Directed self-checking bench for fetch_stage_control with hand-computed expectations.
// Memory returns fixed words at 0 and 4 and 32'hE000_0000 | pc elsewhere.
module tb_fetch_stage_control;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  fetch_stage_control_if bus ();

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] perf_stall_cycles, perf_flush_cycles, perf_squashes;
`endif

  fetch_stage_control #(
    .RESET_PC (32'h0000_0000),
    .MAX_STALL(4),
    .NOP_WORD (32'h0000_0000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .perf_stall_cycles(perf_stall_cycles),
    .perf_flush_cycles(perf_flush_cycles),
    .perf_squashes    (perf_squashes)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr)
      32'h0000_0000: mem_word = 32'h2001_0005;
      32'h0000_0004: mem_word = 32'h2002_0007;
      default:       mem_word = 32'hE000_0000 | addr;
    endcase
  endfunction

  assign bus.IF_instruction = mem_word(bus.IF_pc);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic f, input logic bt, input logic [31:0] tgt);
    bus.stall            = s;
    bus.flush            = f;
    bus.ID_branch_taken  = bt;
    bus.ID_branch_target = tgt;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkFetch(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic valid);
    checkOutput({tag, "_pc"}, bus.IF_pc, pc);
    checkOutput({tag, "_instr"}, bus.ID_instruction, instr);
    checkOutput({tag, "_pc4"}, bus.ID_pc_plus4, pc4);
    checkOutput({tag, "_valid"}, {31'd0, bus.ID_valid}, {31'd0, valid});
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();

    checkFetch("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    checkOutput("reset_err", {31'd0, bus.stall_error}, 32'd0);
    checkOutput("reset_bubble", {31'd0, bus.EX_bubble}, 32'd1);
`ifdef FETCH_PERF_COUNTERS_EN
    checkOutput("reset_perf_stall", perf_stall_cycles, 32'd0);
    checkOutput("reset_perf_flush", perf_flush_cycles, 32'd0);
    checkOutput("reset_perf_squash", perf_squashes, 32'd0);
`endif

    // Free run from reset.
    reset = 1'b0;
    #1;
    checkOutput("boot_bubble", {31'd0, bus.EX_bubble}, 32'd1);
    tick();
    checkFetch("run1", 32'h4, 32'h2001_0005, 32'h4, 1'b1);
    checkOutput("run1_bubble", {31'd0, bus.EX_bubble}, 32'd0);
    tick();
    checkFetch("run2", 32'h8, 32'h2002_0007, 32'h8, 1'b1);

    // Load-use stall with flush at pc 8.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("lu_bubble", {31'd0, bus.EX_bubble}, 32'd1);
    tick();
    checkFetch("lu_hold", 32'h8, 32'h2002_0007, 32'h8, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("lu_release_bubble", {31'd0, bus.EX_bubble}, 32'd0);
    tick();
    checkFetch("lu_go", 32'hC, 32'hE000_0008, 32'hC, 1'b1);
    tick();
    checkFetch("pre_br", 32'h10, 32'hE000_000C, 32'h10, 1'b1);

    // Taken branch at pc 0x10.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h40);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkFetch("br", 32'h40, 32'h0, 32'h10, 1'b0);
    checkOutput("br_bubble", {31'd0, bus.EX_bubble}, 32'd1);
    tick();
    checkFetch("br_next", 32'h44, 32'hE000_0040, 32'h44, 1'b1);

    // A stall outranks the branch, then the branch redirects once.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h80);
    tick();
    checkOutput("sb_hold1", bus.IF_pc, 32'h44);
    tick();
    checkOutput("sb_hold2", bus.IF_pc, 32'h44);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h80);
    tick();
    checkFetch("sb_redir", 32'h80, 32'h0, 32'h44, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checkFetch("sb_after", 32'h84, 32'hE000_0080, 32'h84, 1'b1);
    checkOutput("sb_no_err", {31'd0, bus.stall_error}, 32'd0);

    // Watchdog: five stalled edges against MAX_STALL of 4.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      checkOutput($sformatf("wd_err%0d", i), {31'd0, bus.stall_error}, (i >= 4) ? 32'd1 : 32'd0);
    end
    checkOutput("wd_pc", bus.IF_pc, 32'h84);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("wd_sticky", {31'd0, bus.stall_error}, 32'd1);
    checkOutput("wd_pc_go", bus.IF_pc, 32'h88);

    // Wrap and an unaligned target.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("wrap_pc", bus.IF_pc, 32'hFFFF_FFFC);
    tick();
    checkFetch("wrap", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h13);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checkFetch("unaligned", 32'h17, 32'hE000_0013, 32'h17, 1'b1);

    // Reset during HOLD at pc 0x24, with a branch pending.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h24);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("hold_pc", bus.IF_pc, 32'h24);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h100);
    tick();
    checkFetch("rst_hold", 32'h0, 32'h0, 32'h0, 1'b0);
    checkOutput("rst_hold_err", {31'd0, bus.stall_error}, 32'd0);
`ifdef FETCH_PERF_COUNTERS_EN
    checkOutput("rst_perf_stall", perf_stall_cycles, 32'd0);
    checkOutput("rst_perf_flush", perf_flush_cycles, 32'd0);
    checkOutput("rst_perf_squash", perf_squashes, 32'd0);
`endif

    // BOOT fetches despite stall. The next stalled edge in RUN holds.
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    checkFetch("boot_stall", 32'h4, 32'h2001_0005, 32'h4, 1'b1);
    tick();
    checkOutput("run_stall_pc", bus.IF_pc, 32'h4);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checkFetch("resume", 32'h8, 32'h2002_0007, 32'h8, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
